// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its requester arbiter:
// ALUControl codes, NZCV flag bit positions and the arbiter FSM states.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SLR = 4'b0110;
    localparam logic [3:0] ALU_SAR = 4'b0111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or above the
// pointer, wrapping around. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     grant,
    output logic               any_valid
);

    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDW'(s);
    endfunction

    // Walk downward so the last hit written is the closest one above ptr.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[wrap_idx(ptr, i)]) begin
                grant     = wrap_idx(ptr, i);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters: round-robin accept,
// one cycle of registered ALU operands, then a held per-requester response.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 2,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]     req_ctrl,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [WIDTH-1:0]         resp_result,
    output logic [3:0]               resp_flags,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [3:0]               alu_ctrl,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic                     alu_z,
    input  logic                     alu_n,
    input  logic                     alu_v,
    input  logic                     alu_c,
    output logic                     busy
);

    arb_state_t           state_q;
    logic [IDW-1:0]       ptr_q;
    logic [IDW-1:0]       id_q;
    logic [WIDTH-1:0]     alu_a_q;
    logic [WIDTH-1:0]     alu_b_q;
    logic [3:0]           alu_ctrl_q;
    logic [WIDTH-1:0]     result_q;
    logic [3:0]           flags_q;
    logic [3:0]           flags_d;
    logic [NUM_REQ-1:0]   resp_valid_q;

    logic [IDW-1:0]       grant;
    logic                 any_valid;
    logic [WIDTH-1:0]     sel_a;
    logic [WIDTH-1:0]     sel_b;
    logic [3:0]           sel_ctrl;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .any_valid (any_valid)
    );

    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_ctrl = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == IDW'(i)) begin
                sel_a    = req_a[i*WIDTH +: WIDTH];
                sel_b    = req_b[i*WIDTH +: WIDTH];
                sel_ctrl = req_ctrl[i*4 +: 4];
            end
        end
    end

    always_comb begin
        flags_d         = '0;
        flags_d[FLAG_N] = alu_n;
        flags_d[FLAG_Z] = alu_z;
        flags_d[FLAG_C] = alu_c;
        flags_d[FLAG_V] = alu_v;
    end

    // Ready is only offered while IDLE, and only to the single winner.
    assign req_ready = (state_q == IDLE && any_valid) ? (NUM_REQ'(1) << grant) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            result_q     <= '0;
            flags_q      <= '0;
            resp_valid_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        alu_a_q    <= sel_a;
                        alu_b_q    <= sel_b;
                        alu_ctrl_q <= sel_ctrl;
                        id_q       <= grant;
                        state_q    <= EXEC;
                    end
                end
                EXEC: begin
                    result_q     <= alu_result;
                    flags_q      <= flags_d;
                    resp_valid_q <= NUM_REQ'(1) << id_q;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready[id_q]) begin
                        resp_valid_q <= '0;
                        ptr_q        <= (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_ctrl    = alu_ctrl_q;
    assign resp_result = result_q;
    assign resp_flags  = flags_q;
    assign resp_valid  = resp_valid_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 4-bit ALU and a
// response scoreboard of hand-derived results.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int WIDTH   = 4;
    localparam int NUM_REQ = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ*4-1:0]     req_ctrl;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [NUM_REQ-1:0]       resp_ready;
    logic [WIDTH-1:0]         resp_result;
    logic [3:0]               resp_flags;
    logic [WIDTH-1:0]         alu_a;
    logic [WIDTH-1:0]         alu_b;
    logic [3:0]               alu_ctrl;
    logic [WIDTH-1:0]         alu_result;
    logic                     alu_z, alu_n, alu_v, alu_c;
    logic                     busy;
    logic [4:0]               alu_s;

    typedef struct {
        int         id;
        logic [3:0] res;
        logic [3:0] flg;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ctrl    (req_ctrl),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_flags  (resp_flags),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .alu_z       (alu_z),
        .alu_n       (alu_n),
        .alu_v       (alu_v),
        .alu_c       (alu_c),
        .busy        (busy)
    );

    // Behavioural ALU: ARM-style flags, C=1 means no borrow on SUB.
    always_comb begin
        alu_s      = '0;
        alu_result = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        case (alu_ctrl)
            ALU_ADD: begin
                alu_s      = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = alu_s[3:0];
                alu_c      = alu_s[4];
                alu_v      = (alu_a[3] == alu_b[3]) && (alu_s[3] != alu_a[3]);
            end
            ALU_SUB: begin
                alu_s      = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
                alu_result = alu_s[3:0];
                alu_c      = alu_s[4];
                alu_v      = (alu_a[3] != alu_b[3]) && (alu_s[3] != alu_a[3]);
            end
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_ORR: alu_result = alu_a | alu_b;
            ALU_XOR: alu_result = alu_a ^ alu_b;
            ALU_SLL: alu_result = alu_a << alu_b;
            ALU_SLR: alu_result = alu_a >> alu_b;
            ALU_SAR: alu_result = $signed(alu_a) >>> alu_b;
            default: alu_result = '0;
        endcase
        alu_n = alu_result[3];
        alu_z = (alu_result == '0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
            chk("resp_onehot", 32'($countones(resp_valid) <= 1), 1);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input int id, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        req_a[id*4 +: 4]    = a;
        req_b[id*4 +: 4]    = b;
        req_ctrl[id*4 +: 4] = c;
        req_valid[id]       = 1'b1;
    endtask

    task automatic expect_resp(input int id, input logic [3:0] r, input logic [3:0] f);
        exp_t e;
        e.id  = id;
        e.res = r;
        e.flg = f;
        sb.push_back(e);
    endtask

    // Starts and ends 1 time unit after a rising edge.
    task automatic wait_accept(input int id, input bit drop);
        int n = 0;
        bit got = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            if (req_ready != '0) begin
                got = 1;
                chk("grant", 32'(req_ready), 32'(1) << id);
            end else begin
                @(posedge clk); #1;
                n++;
            end
        end
        if (!got) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        if (drop) req_valid[id] = 1'b0;
    endtask

    task automatic collect(input int hold);
        int w = 0;
        exp_t e;
        logic [NUM_REQ-1:0] v0;
        logic [3:0] r0, f0, a0, b0, c0;
        @(negedge clk);
        while (resp_valid == '0 && w < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            w++;
        end
        chk("resp_latency", w, 1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
            e.id = 0; e.res = '0; e.flg = '0;
        end else begin
            e = sb.pop_front();
        end
        chk("resp_valid", 32'(resp_valid), 32'(1) << e.id);
        chk("resp_result", 32'(resp_result), 32'(e.res));
        chk("resp_flags", 32'(resp_flags), 32'(e.flg));
        v0 = resp_valid; r0 = resp_result; f0 = resp_flags;
        a0 = alu_a; b0 = alu_b; c0 = alu_ctrl;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            resp_ready = ~v0;
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid), 32'(v0));
            chk("hold_result", 32'(resp_result), 32'(r0));
            chk("hold_flags", 32'(resp_flags), 32'(f0));
            chk("hold_alu_ops", 32'({alu_a, alu_b, alu_ctrl}), 32'({a0, b0, c0}));
            chk("hold_no_ready", 32'(req_ready), 0);
        end
        @(posedge clk); #1;
        resp_ready = v0;
        @(posedge clk); #1;
        resp_ready = '0;
        chk("busy_after_resp", 32'(busy), 0);
        chk("valid_after_resp", 32'(resp_valid), 0);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_ctrl   = '0;
        resp_ready = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_outputs", 32'({resp_result, resp_flags, alu_a, alu_b, alu_ctrl}), 0);
        @(posedge clk); #1;

        // Single request on req0, with operand check during EXEC.
        drive(0, 4'b0110, 4'b0001, ALU_ADD);
        expect_resp(0, 4'b0111, 4'b0000);
        wait_accept(0, 1);
        chk("exec_busy", 32'(busy), 1);
        chk("exec_ops", 32'({alu_a, alu_b, alu_ctrl}), 32'({4'b0110, 4'b0001, ALU_ADD}));
        chk("exec_no_resp", 32'(resp_valid), 0);
        collect(0);

        // Overflow and borrow on req1.
        drive(1, 4'b0111, 4'b0001, ALU_ADD);
        expect_resp(1, 4'b1000, 4'b1001);
        wait_accept(1, 1);
        collect(0);
        drive(1, 4'b0001, 4'b0111, ALU_SUB);
        expect_resp(1, 4'b1010, 4'b1000);
        wait_accept(1, 1);
        collect(0);

        // Backpressure with req1 pending, stray resp_ready on the other index.
        drive(0, 4'b0011, 4'b0100, ALU_ADD);
        expect_resp(0, 4'b0111, 4'b0000);
        wait_accept(0, 1);
        drive(1, 4'b1100, 4'b1110, ALU_AND);
        expect_resp(1, 4'b1100, 4'b1000);
        collect(5);
        wait_accept(1, 1);
        collect(0);

        // Zero result and shift on req0.
        drive(0, 4'b1111, 4'b1111, ALU_XOR);
        expect_resp(0, 4'b0000, 4'b0100);
        wait_accept(0, 1);
        collect(0);
        drive(0, 4'b0011, 4'b0001, ALU_SLL);
        expect_resp(0, 4'b0110, 4'b0000);
        wait_accept(0, 1);
        collect(0);

        // Reset while req1 is in EXEC; pointer must return to 0.
        drive(1, 4'b0101, 4'b0101, ALU_ADD);
        wait_accept(1, 1);
        chk("pre_reset_busy", 32'(busy), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(resp_valid), 0);
        chk("mid_rst_outputs", 32'({resp_result, resp_flags, alu_a, alu_b, alu_ctrl}), 0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("no_dropped_resp", 32'({busy, resp_valid}), 0);
        end
        drive(0, 4'b1010, 4'b0101, ALU_ORR);
        drive(1, 4'b1000, 4'b0001, ALU_SAR);
        expect_resp(0, 4'b1111, 4'b1000);
        expect_resp(1, 4'b1100, 4'b1000);
        wait_accept(0, 1);
        collect(0);
        wait_accept(1, 1);
        collect(0);

        // Contention: both valid from reset, grant order 0,1,0,1.
        reset = 1'b1;
        drive(0, 4'b1111, 4'b1111, ALU_ADD);
        drive(1, 4'b1100, 4'b1110, ALU_AND);
        for (int k = 0; k < 2; k++) begin
            expect_resp(0, 4'b1110, 4'b1010);
            expect_resp(1, 4'b1100, 4'b1000);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_accept(k % 2, 0);
            collect(0);
        end
        req_valid = '0;
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU between NUM_REQ requesters, for example the execute stage and a debug/flag-test port.
- Each requester issues {a, b, ALUControl} over a valid/ready handshake.
- The block arbitrates round-robin, drives the shared ALU from registered operands, captures result and NZCV, and returns them over a per-requester response handshake.
- Sits between the requesters and the ALU instance; the ALU itself is unchanged.

Parameters:
- WIDTH, 4, operand/result width; must match the ALU instance.
- NUM_REQ, 2, number of requesters (2..8).
- IDW, $clog2(NUM_REQ), requester index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  request present, one bit per requester.
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero).
- req_a  in  NUM_REQ x WIDTH  operand a per requester.
- req_b  in  NUM_REQ x WIDTH  operand b per requester.
- req_ctrl  in  NUM_REQ x 4  ALUControl per requester.
- resp_valid  out  NUM_REQ  response present (one-hot or zero).
- resp_ready  in  NUM_REQ  requester consumes response.
- resp_result  out  WIDTH  captured ALU result.
- resp_flags  out  4  captured {N,Z,C,V}.
- alu_a  out  WIDTH  to ALU a.
- alu_b  out  WIDTH  to ALU b.
- alu_ctrl  out  4  to ALU ALUControl.
- alu_result  in  WIDTH  from ALU.
- alu_z, alu_n, alu_v, alu_c  in  1 each  from ALU.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: synchronous, active-high. Every output and register goes to 0, FSM goes to IDLE, rr pointer goes to 0. A reset in any state discards the in-flight operation with no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req_valid is set, the grant is the first valid index searching upward from the rr pointer, wrapping.
  - req_ready[grant] = 1 combinationally in that cycle only.
  - On the edge: latch a/b/ctrl into the operand regs, latch grant into id_q, go to EXEC.
  - If no request, stay in IDLE.
- EXEC: alu_a/alu_b/alu_ctrl are driven from the operand regs; they are registered outputs, stable for the whole state. On the edge, capture alu_result into resp_result and {alu_n,alu_z,alu_c,alu_v} into resp_flags, then go to RESP.
- RESP: resp_valid[id_q] = 1. Result and flags are held stable until resp_ready[id_q] is high.
  - On that handshake edge: go to IDLE and set the rr pointer to (id_q+1) mod NUM_REQ.
  - resp_ready on other indices is ignored.
- Latency and throughput: accept edge T gives resp_valid high from T+2. Back-to-back throughput is one operation per 3 cycles.
- No new request is accepted outside IDLE; req_ready is 0 in EXEC and RESP.
- Requesters hold req_* stable while req_valid is high. A requester may drop req_valid before acceptance without effect.
- Simultaneous requests: only one grant per IDLE cycle; the losers keep waiting.
- Fairness: a requester that holds valid is granted within NUM_REQ transactions.
- ALUControl is passed through unmodified. Codes outside the package's defined ops yield whatever the ALU produces; no error is raised.
- Flags are captured as-is. The block does no interpretation; C follows ALU convention (ARM: C=1 means no borrow on SUB).
- alu_* outputs keep their last value in IDLE and RESP.

Decomposition:
- Shared package alu_pkg:
  - ALUControl constants: ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_AND=4'b0010, ALU_ORR=4'b0011, ALU_XOR=4'b0100, ALU_SLL=4'b0101, ALU_SLR=4'b0110, ALU_SAR=4'b0111.
  - Flag bit indices: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FSM enum arb_state_t {IDLE, EXEC, RESP}.
- One sub-module, rr_arbiter: combinational priority pick from (req_valid, pointer), outputs grant index and any_valid. The pointer register stays in alu_arbiter.

Test Plan:
- Single request: reset, then req0 ADD a=0110 b=0001 at edge T. Expect req_ready=01 at T, resp_valid=01 from T+2, resp_result=0111, flags N0 Z0 C0 V0. Release with resp_ready[0]; busy returns to 0.
- Overflow and borrow: req1 ADD 0111+0001 gives 1000 with N1 Z0 C0 V1. Then req1 SUB 0001-0111 gives 1010 with N1 C0 V0. resp_valid=10 each time.
- Contention and fairness: both valid continuously from reset for 4 transactions.
  - req0 issues ADD 1111+1111, giving 1110 with N1 C1.
  - req1 issues AND 1100&1110, giving 1100.
  - Grant order must be 0,1,0,1 and req_ready must never be two-hot.
- Backpressure: resp_ready held 0 for 5 cycles in RESP. Expect resp_valid, resp_result and resp_flags unchanged, req_ready=0 despite pending req1, and no ALU operand change.
- Reset mid-operation: assert reset in EXEC. Next cycle all outputs are 0 and the state is IDLE. No response is ever issued for the dropped request. The first post-reset grant goes to req0.
- Zero result: XOR 1111^1111 gives 0000 with Z1 N0; SLL a=0011 b=0001 gives 0110.
